// File: rtl/gf2m_mul_ctrl.sv
// gf2m_mul_ctrl: sequencer for an MSB-first GF(2^W) multiply on an external
// shift/xor ALU. The ALU holds the accumulator; this block only issues the
// store/shift/add commands and tracks the multiplier bits.
// Optional build macro GF2M_MUL_SKIP_ZERO_EN: while the accumulator is still
// zero, leading zero multiplier bits are consumed in one SKIP cycle each
// instead of a full shift round trip. The product is identical either way.
module gf2m_mul_ctrl #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] poly,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         alu_add,
    output logic         alu_shl,
    output logic         alu_sto,
    output logic [W-1:0] alu_sbus,
    input  logic [W-1:0] alu_dbus,
    input  logic         alu_mz,
    input  logic         alu_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLR   = 4'd1;
    localparam logic [3:0] S_SHL   = 4'd2;
    localparam logic [3:0] S_SHL_W = 4'd3;
    localparam logic [3:0] S_RED   = 4'd4;
    localparam logic [3:0] S_RED_W = 4'd5;
    localparam logic [3:0] S_ACC   = 4'd6;
    localparam logic [3:0] S_ACC_W = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;
`ifdef GF2M_MUL_SKIP_ZERO_EN
    localparam logic [3:0] S_SKIP  = 4'd9;
`endif

    logic [3:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          red_q, red_d;
    logic          next_bit;
`ifdef GF2M_MUL_SKIP_ZERO_EN
    logic          acc_zero_q, acc_zero_d;
`endif

    // Next-state and datapath register updates; next_bit marks the end of a
    // multiplier bit and is resolved once after the case statement.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        red_d      = red_q;
        result_d   = result_q;
        next_bit   = 1'b0;
`ifdef GF2M_MUL_SKIP_ZERO_EN
        acc_zero_d = acc_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = CNT_INIT;
                end
            end
            S_CLR: begin
`ifdef GF2M_MUL_SKIP_ZERO_EN
                acc_zero_d = 1'b1;
                // Accumulator is being cleared, so a zero top bit needs no shift.
                if (alu_done) state_d = b_q[W-1] ? S_SHL : S_SKIP;
`else
                if (alu_done) state_d = S_SHL;
`endif
            end
            S_SHL:   state_d = S_SHL_W;
            S_SHL_W: begin
                if (alu_done) begin
                    red_d = alu_mz;
                    // Reduction always precedes the accumulate of the same bit.
                    if (alu_mz)        state_d  = S_RED;
                    else if (b_q[W-1]) state_d  = S_ACC;
                    else               next_bit = 1'b1;
                end
            end
            S_RED:   state_d = S_RED_W;
            S_RED_W: begin
                if (alu_done) begin
                    if (b_q[W-1]) state_d  = S_ACC;
                    else          next_bit = 1'b1;
                end
            end
            S_ACC: begin
                state_d = S_ACC_W;
`ifdef GF2M_MUL_SKIP_ZERO_EN
                acc_zero_d = 1'b0;
`endif
            end
            S_ACC_W: begin
                if (alu_done) next_bit = 1'b1;
            end
`ifdef GF2M_MUL_SKIP_ZERO_EN
            S_SKIP:  next_bit = 1'b1;
`endif
            S_FIN: begin
                result_d = alu_dbus;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (next_bit) begin
            b_d = {b_q[W-2:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
`ifdef GF2M_MUL_SKIP_ZERO_EN
                // b_q[W-2] becomes the MSB of the following bit.
                state_d = (acc_zero_q && !b_q[W-2]) ? S_SKIP : S_SHL;
`else
                state_d = S_SHL;
`endif
            end else begin
                state_d = S_FIN;
            end
        end
    end

    // State and datapath registers, cleared asynchronously even mid-operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            red_q      <= 1'b0;
            result_q   <= '0;
`ifdef GF2M_MUL_SKIP_ZERO_EN
            acc_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            red_q      <= red_d;
            result_q   <= result_d;
`ifdef GF2M_MUL_SKIP_ZERO_EN
            acc_zero_q <= acc_zero_d;
`endif
        end
    end

    // ALU command decode: at most one strobe, source bus zero when idle.
    always_comb begin
        alu_add  = 1'b0;
        alu_shl  = 1'b0;
        alu_sto  = 1'b0;
        alu_sbus = '0;
        case (state_q)
            S_CLR: alu_sto = 1'b1;
            S_SHL: begin
                alu_shl  = 1'b1;
                alu_sbus = alu_dbus;
            end
            S_RED: begin
                alu_add  = 1'b1;
                alu_sbus = poly;
            end
            S_ACC: begin
                alu_add  = 1'b1;
                alu_sbus = a_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_FIN);
    assign result = result_q;

endmodule

// File: tb/tb_gf2m_mul_ctrl.sv
// Bench for gf2m_mul_ctrl: a W=256 instance on a zero-latency ALU model for
// cycle-exact checks, and a W=8 instance on a stalling ALU model for a long
// random run. Expected products come from a carry-less multiply followed by
// polynomial long division; results are queued at start and popped at done.
module tb_gf2m_mul_ctrl;
    localparam int WB = 256;
    localparam int WS = 8;
`ifdef GF2M_MUL_SKIP_ZERO_EN
    localparam int EXP_ONE = 261, EXP_ZERO = 258, EXP_ZERO_SHL = 0;
`else
    localparam int EXP_ONE = 516, EXP_ZERO = 514, EXP_ZERO_SHL = 256;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          b_start, b_busy, b_done, b_add, b_shl, b_sto, b_mz, b_alu_done;
    logic [WB-1:0] b_a, b_b, b_poly, b_result, b_sbus, b_acc;
    logic          s_start, s_busy, s_done, s_add, s_shl, s_sto, s_mz, s_alu_done;
    logic [WS-1:0] s_a, s_b, s_poly, s_result, s_sbus, s_acc;
    logic [1:0]    s_stall;

    gf2m_mul_ctrl #(.W(WB)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .op_a(b_a), .op_b(b_b), .poly(b_poly),
        .busy(b_busy), .done(b_done), .result(b_result),
        .alu_add(b_add), .alu_shl(b_shl), .alu_sto(b_sto), .alu_sbus(b_sbus),
        .alu_dbus(b_acc), .alu_mz(b_mz), .alu_done(b_alu_done)
    );

    gf2m_mul_ctrl #(.W(WS)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .op_a(s_a), .op_b(s_b), .poly(s_poly),
        .busy(s_busy), .done(s_done), .result(s_result),
        .alu_add(s_add), .alu_shl(s_shl), .alu_sto(s_sto), .alu_sbus(s_sbus),
        .alu_dbus(s_acc), .alu_mz(s_mz), .alu_done(s_alu_done)
    );

    // Wide ALU: each command completes at the edge that ends its strobe cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_acc <= '0;
            b_mz  <= 1'b0;
        end else if (b_sto) begin
            b_acc <= b_sbus;
        end else if (b_shl) begin
            b_acc <= {b_sbus[WB-2:0], 1'b0};
            b_mz  <= b_sbus[WB-1];
        end else if (b_add) begin
            b_acc <= b_acc ^ b_sbus;
        end
    end
    assign b_alu_done = 1'b1;

    // Narrow ALU: shift/add hold alu_done low for a random extra cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_acc   <= '0;
            s_mz    <= 1'b0;
            s_stall <= '0;
        end else if (s_stall != 2'd0) begin
            s_stall <= s_stall - 2'd1;
        end else if (s_sto) begin
            s_acc <= s_sbus;
        end else if (s_shl) begin
            s_acc   <= {s_sbus[WS-2:0], 1'b0};
            s_mz    <= s_sbus[WS-1];
            s_stall <= 2'($urandom_range(0, 1));
        end else if (s_add) begin
            s_acc   <= s_acc ^ s_sbus;
            s_stall <= 2'($urandom_range(0, 1));
        end
    end
    assign s_alu_done = (s_stall == 2'd0);

    // Strobe/event counters; tests work on differences of these.
    int shl_cnt = 0, add_cnt = 0, red_cnt = 0, red_shl = 0, done_cnt = 0, strobe_bad = 0;
    int s_done_cnt = 0, s_strobe_bad = 0;
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            if (b_shl) shl_cnt <= shl_cnt + 1;
            if (b_add) add_cnt <= add_cnt + 1;
            if (b_add && b_sbus == b_poly) begin
                red_cnt <= red_cnt + 1;
                red_shl <= shl_cnt;
            end
            if (b_done) done_cnt <= done_cnt + 1;
            if ($countones({b_add, b_shl, b_sto}) > 1 ||
                ((b_add | b_shl | b_sto) && (!b_busy || b_done)) ||
                (!(b_add | b_shl | b_sto) && b_sbus != '0))
                strobe_bad <= strobe_bad + 1;
            if (s_done) s_done_cnt <= s_done_cnt + 1;
            if ($countones({s_add, s_shl, s_sto}) > 1 ||
                ((s_add | s_shl | s_sto) && (!s_busy || s_done)) ||
                (!(s_add | s_shl | s_sto) && s_sbus != '0))
                s_strobe_bad <= s_strobe_bad + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [WB-1:0] q_big[$];
    logic [WS-1:0] q_small[$];

    // Reference product: carry-less multiply, then reduce by x^w + p.
    function automatic logic [255:0] gf_ref(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] p, input int w);
        logic [511:0] prod, rp;
        prod = '0;
        for (int i = 0; i < w; i++) if (b[i]) prod = prod ^ (512'(a) << i);
        rp = 512'(p);
        rp[w] = 1'b1;
        for (int i = 2 * w - 2; i >= w; i--) if (prod[i]) prod = prod ^ (rp << (i - w));
        return prod[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic big_go(input logic [WB-1:0] a, input logic [WB-1:0] b);
        b_a = a;
        b_b = b;
        b_start = 1'b1;
        q_big.push_back(gf_ref(a, b, b_poly, WB));
        @(posedge clk);
        #1 b_start = 1'b0;
    endtask

    // n = cycle (1 = first after the accept edge) in which done was seen.
    task automatic big_wait(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 4000 && !ok) begin
            @(negedge clk);
            n++;
            ok = b_done;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        logic [WB-1:0] exp;
        @(negedge clk);
        n_cmp++; if ({b_busy, b_done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b expected 00", {b_busy, b_done}); end
        n_cmp++; if (b_result !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", b_result); end
        n_cmp++; if ({b_add, b_shl, b_sto} !== 3'b000 || b_sbus !== '0) begin n_bad++; $display("FAIL reset_strobes: got %b sbus %h expected 000/0", {b_add, b_shl, b_sto}, b_sbus); end
        n_cmp++; if ({s_busy, s_done, s_add, s_shl, s_sto} !== 5'b0 || s_result !== '0) begin n_bad++; $display("FAIL reset_small: got %b/%h expected 0/0", {s_busy, s_done, s_add, s_shl, s_sto}, s_result); end
        reset = 1'b0;
        big_go(rnd256(), rnd256());
        n_cmp++; if (b_busy !== 1'b1) begin n_bad++; $display("FAIL first_edge_accept: busy %b expected 1", b_busy); end
        big_wait(n, ok);
        exp = q_big.pop_front();
        n_cmp++; if (!ok || b_result !== exp) begin n_bad++; $display("FAIL first_product: ok %0d got %h expected %h", ok, b_result, exp); end
    endtask

    task automatic test_unit_product();
        int n;
        bit ok;
        logic [WB-1:0] exp;
        big_go(256'd1, 256'd1);
        big_wait(n, ok);
        exp = q_big.pop_front();
        n_cmp++; if (!ok || b_result !== exp) begin n_bad++; $display("FAIL unit_result: ok %0d got %h expected %h", ok, b_result, exp); end
        n_cmp++; if (n !== EXP_ONE) begin n_bad++; $display("FAIL unit_latency: done in cycle %0d expected %0d", n, EXP_ONE); end
    endtask

    task automatic test_zero_b();
        int n, shl0, add0;
        bit ok;
        logic [WB-1:0] exp;
        shl0 = shl_cnt;
        add0 = add_cnt;
        big_go(rnd256(), '0);
        big_wait(n, ok);
        exp = q_big.pop_front();
        n_cmp++; if (!ok || b_result !== exp) begin n_bad++; $display("FAIL zero_b_result: ok %0d got %h expected %h", ok, b_result, exp); end
        n_cmp++; if (n !== EXP_ZERO) begin n_bad++; $display("FAIL zero_b_latency: done in cycle %0d expected %0d", n, EXP_ZERO); end
        n_cmp++; if (add_cnt - add0 !== 0) begin n_bad++; $display("FAIL zero_b_adds: got %0d expected 0", add_cnt - add0); end
        n_cmp++; if (shl_cnt - shl0 !== EXP_ZERO_SHL) begin n_bad++; $display("FAIL zero_b_shifts: got %0d expected %0d", shl_cnt - shl0, EXP_ZERO_SHL); end
    endtask

    task automatic test_reduction();
        int n, shl0, red0;
        bit ok;
        logic [WB-1:0] b, exp;
        b = '0;
        b[WB-1] = 1'b1;
        shl0 = shl_cnt;
        red0 = red_cnt;
        big_go(256'd2, b);
        big_wait(n, ok);
        exp = q_big.pop_front();
        n_cmp++; if (!ok || b_result !== exp) begin n_bad++; $display("FAIL reduction_result: ok %0d got %h expected %h", ok, b_result, exp); end
        n_cmp++; if (red_cnt - red0 !== 1) begin n_bad++; $display("FAIL reduction_count: got %0d expected 1", red_cnt - red0); end
        n_cmp++; if (red_shl - shl0 !== WB) begin n_bad++; $display("FAIL reduction_bit: after shift %0d expected %0d", red_shl - shl0, WB); end
    endtask

    task automatic test_reset_mid_op();
        int n, d0;
        bit ok, found;
        logic [WB-1:0] a, exp;
        a = rnd256();
        big_go(a, '1);
        found = 1'b0;
        n = 0;
        while (n < 600 && !found) begin
            @(negedge clk);
            n++;
            found = b_add && (b_sbus == a);
        end
        @(negedge clk);
        n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_op_acc_seen: no ACC within %0d cycles", n); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if ({b_busy, b_done} !== 2'b00) begin n_bad++; $display("FAIL mid_op_busy_drop: got %b expected 00", {b_busy, b_done}); end
        n_cmp++; if (b_result !== '0 || {b_add, b_shl, b_sto} !== 3'b000) begin n_bad++; $display("FAIL mid_op_clear: result %h strobes %b expected 0/000", b_result, {b_add, b_shl, b_sto}); end
        void'(q_big.pop_back());
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        big_go(256'd3, 256'd3);
        big_wait(n, ok);
        exp = q_big.pop_front();
        n_cmp++; if (!ok || b_result !== exp) begin n_bad++; $display("FAIL after_reset_product: ok %0d got %h expected %h", ok, b_result, exp); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL after_reset_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_start_held();
        int n, d0;
        bit ok;
        logic [WB-1:0] exp;
        d0 = done_cnt;
        b_a = 256'd1;
        b_b = 256'd1;
        b_start = 1'b1;
        q_big.push_back(gf_ref(256'd1, 256'd1, b_poly, WB));
        @(posedge clk);
        #1;
        n = 0;
        ok = 1'b0;
        while (n < 4000 && !ok) begin
            @(negedge clk);
            n++;
            ok = b_done;
        end
        @(posedge clk);
        #1 b_start = 1'b0;
        exp = q_big.pop_front();
        n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL start_in_fin_ignored: busy %b expected 0", b_busy); end
        n_cmp++; if (!ok || n !== EXP_ONE) begin n_bad++; $display("FAIL held_start_latency: done in cycle %0d expected %0d", n, EXP_ONE); end
        n_cmp++; if (b_result !== exp) begin n_bad++; $display("FAIL held_start_result: got %h expected %h", b_result, exp); end
        repeat (3) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 1 || b_busy !== 1'b0) begin n_bad++; $display("FAIL held_start_done_count: got %0d busy %b expected 1/0", done_cnt - d0, b_busy); end
    endtask

    task automatic test_random_big();
        int n, sb0;
        bit ok;
        logic [WB-1:0] exp;
        sb0 = strobe_bad;
        for (int v = 0; v < 12; v++) begin
            big_go(rnd256(), rnd256());
            big_wait(n, ok);
            exp = q_big.pop_front();
            n_cmp++; if (!ok || b_result !== exp) begin n_bad++; $display("FAIL random_big[%0d]: ok %0d got %h expected %h", v, ok, b_result, exp); end
        end
        n_cmp++; if (strobe_bad - sb0 !== 0 || strobe_bad !== 0) begin n_bad++; $display("FAIL big_strobe_rules: got %0d violations expected 0", strobe_bad); end
    endtask

    task automatic test_random_small();
        int n, d0;
        bit ok;
        logic [WS-1:0] exp;
        d0 = s_done_cnt;
        for (int v = 0; v < 1000; v++) begin
            s_a = WS'($urandom);
            s_b = WS'($urandom);
            s_start = 1'b1;
            q_small.push_back(WS'(gf_ref(256'(s_a), 256'(s_b), 256'(s_poly), WS)));
            @(posedge clk);
            #1 s_start = 1'b0;
            n = 0;
            ok = 1'b0;
            while (n < 200 && !ok) begin
                @(negedge clk);
                n++;
                ok = s_done;
            end
            @(posedge clk);
            #1;
            exp = q_small.pop_front();
            n_cmp++; if (!ok || s_result !== exp) begin n_bad++; $display("FAIL random_small[%0d]: a %h b %h ok %0d got %h expected %h", v, s_a, s_b, ok, s_result, exp); end
        end
        n_cmp++; if (s_done_cnt - d0 !== 1000) begin n_bad++; $display("FAIL small_done_count: got %0d expected 1000", s_done_cnt - d0); end
        n_cmp++; if (s_strobe_bad !== 0) begin n_bad++; $display("FAIL small_strobe_rules: got %0d violations expected 0", s_strobe_bad); end
    endtask

    initial begin
        reset   = 1'b1;
        b_start = 1'b0;
        b_a     = '0;
        b_b     = '0;
        b_poly  = 256'h425;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_poly  = 8'h1B;
        test_reset();
        test_unit_product();
        test_zero_b();
        test_reduction();
        test_reset_mid_op();
        test_start_held();
        test_random_big();
        test_random_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
